// File: rtl/iq_playback_if.sv
// Handshake/data bundle between a CPU-side loader and the I/Q playback buffer.
// The master side loads samples and controls playback; the slave side is the buffer.
interface iq_playback_if #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16,
  parameter int MAXI  = 32768
);
  localparam int AW = $clog2(DEPTH);
  localparam int MI = ($clog2(MAXI) > 1) ? $clog2(MAXI) : 1;

  logic             set_interp;
  logic [MI-1:0]    interp_in;
  logic             wr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             stop;
  logic             continuous;
  logic             out_strobe;
  logic [WIDTH-1:0] out_i;
  logic [WIDTH-1:0] out_q;
  logic             running;
  logic             full;
  logic [AW:0]      count;
  logic             underrun;

  modport master (
    output set_interp, interp_in, wr, wr_data, start, stop, continuous,
    input  out_strobe, out_i, out_q, running, full, count, underrun
  );

  modport slave (
    input  set_interp, interp_in, wr, wr_data, start, stop, continuous,
    output out_strobe, out_i, out_q, running, full, count, underrun
  );
endinterface

// File: rtl/iq_playback.sv
// CPU-loaded I/Q sample buffer played out at a programmable interval in the adc_clk
// domain, either as a one-shot FIFO or looping continuously over the loaded block.
module iq_playback #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16,
  parameter int MAXI  = 32768
) (
  input logic         clock,
  input logic         reset,
  iq_playback_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MI = ($clog2(MAXI) > 1) ? $clog2(MAXI) : 1;

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [2*WIDTH-1:0] rd_data_r;

  logic [0:0]       state_r;
  logic             running_r;
  logic [MI-1:0]    interval_r;
  logic [MI-1:0]    phase_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_r;
  logic             half_r;
  logic [WIDTH-1:0] stage_i_r;
  logic             cont_r;
  logic [AW:0]      len_r;
  logic [AW-1:0]    loop_r;
  logic [AW-1:0]    pos_r;
  logic             pend_r;
  logic             pend_empty_r;
  logic             out_strobe_r;
  logic [WIDTH-1:0] out_i_r;
  logic [WIDTH-1:0] out_q_r;
  logic             underrun_r;

  logic        run_s;
  logic        empty_s;
  logic        start_ok_s;
  logic        fire_s;
  logic        pop_s;
  logic        wr_ok_s;
  logic        commit_s;
  logic        rewind_s;
  logic        loop_end_s;
  logic [AW:0] count_next_s;

  // Playback decisions for this cycle: state change, read fire, pop, write commit.
  always_comb begin
    run_s        = (state_r == ST_RUN);
    empty_s      = (count_r == {(AW+1){1'b0}});
    start_ok_s   = !run_s && bus.start && !bus.stop && !empty_s;
    fire_s       = run_s && !bus.stop && (phase_r == {MI{1'b0}});
    pop_s        = fire_s && !cont_r && !empty_s;
    wr_ok_s      = bus.wr && !full_r && !(run_s && cont_r);
    commit_s     = wr_ok_s && half_r;
    // A pair already popped but cut off by stop goes back into the buffer.
    rewind_s     = run_s && bus.stop && pend_r && !pend_empty_r && !cont_r && !commit_s;
    loop_end_s   = ({1'b0, pos_r} == (len_r - ONE_C));
    count_next_s = count_r + {{AW{1'b0}}, commit_s} + {{AW{1'b0}}, rewind_s}
                 - {{AW{1'b0}}, pop_s};
  end

  // Sample RAM: pair write on Q commit, registered read when a strobe is due.
  always_ff @(posedge clock) begin
    if (commit_s) begin
      mem_r[wr_ptr_r] <= {stage_i_r, bus.wr_data};
    end
    if (fire_s) begin
      rd_data_r <= mem_r[rd_ptr_r];
    end
  end

  // Control path: interval, write staging, occupancy, state and read pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      running_r  <= 1'b0;
      interval_r <= MI'(1);
      phase_r    <= {MI{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      full_r     <= 1'b0;
      half_r     <= 1'b0;
      stage_i_r  <= {WIDTH{1'b0}};
      cont_r     <= 1'b0;
      len_r      <= {(AW+1){1'b0}};
      loop_r     <= {AW{1'b0}};
      pos_r      <= {AW{1'b0}};
    end else begin
      if (bus.set_interp) begin
        interval_r <= (bus.interp_in == {MI{1'b0}}) ? MI'(1) : bus.interp_in;
      end
      if (wr_ok_s) begin
        if (!half_r) begin
          stage_i_r <= bus.wr_data;
          half_r    <= 1'b1;
        end else begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
          half_r   <= 1'b0;
        end
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);

      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
            cont_r    <= bus.continuous;
            len_r     <= count_r;
            loop_r    <= rd_ptr_r;
            pos_r     <= {AW{1'b0}};
            phase_r   <= {MI{1'b0}};
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end else if (fire_s) begin
            phase_r <= interval_r - MI'(1);
          end else begin
            phase_r <= phase_r - MI'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase

      if (rewind_s) begin
        rd_ptr_r <= rd_ptr_r - AW'(1);
      end else if (fire_s && cont_r) begin
        if (loop_end_s) begin
          rd_ptr_r <= loop_r;
          pos_r    <= {AW{1'b0}};
        end else begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
          pos_r    <= pos_r + AW'(1);
        end
      end else if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Output stage: one cycle after the RAM read, present the pair with a strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r       <= 1'b0;
      pend_empty_r <= 1'b0;
      out_strobe_r <= 1'b0;
      out_i_r      <= {WIDTH{1'b0}};
      out_q_r      <= {WIDTH{1'b0}};
      underrun_r   <= 1'b0;
    end else begin
      pend_r       <= fire_s;
      pend_empty_r <= fire_s && !cont_r && empty_s;
      if (!run_s || bus.stop) begin
        out_strobe_r <= 1'b0;
      end else if (pend_r) begin
        out_strobe_r <= 1'b1;
        if (pend_empty_r) begin
          out_i_r    <= {WIDTH{1'b0}};
          out_q_r    <= {WIDTH{1'b0}};
          underrun_r <= 1'b1;
        end else begin
          out_i_r <= rd_data_r[2*WIDTH-1:WIDTH];
          out_q_r <= rd_data_r[WIDTH-1:0];
        end
      end else begin
        out_strobe_r <= 1'b0;
      end
      if (start_ok_s) begin
        underrun_r <= 1'b0;
      end
    end
  end

  assign bus.out_strobe = out_strobe_r;
  assign bus.out_i      = out_i_r;
  assign bus.out_q      = out_q_r;
  assign bus.running    = running_r;
  assign bus.full       = full_r;
  assign bus.count      = count_r;
  assign bus.underrun   = underrun_r;

endmodule

// File: tb/tb_iq_playback.sv
// Directed bench for iq_playback: one-shot, underrun recovery, continuous looping,
// full buffer, reset mid-run, start/stop collision and zero interval.
module tb_iq_playback;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int MAXI  = 32768;
  localparam int AW    = $clog2(DEPTH);
  localparam int MI    = $clog2(MAXI);

  logic clock = 1'b0;
  logic reset = 1'b1;

  iq_playback_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAXI(MAXI)) bus ();

  iq_playback #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAXI(MAXI)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.set_interp = 1'b0;
    bus.interp_in  = '0;
    bus.wr         = 1'b0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_interval(input int v);
    bus.set_interp = 1'b1;
    bus.interp_in  = MI'(v);
    step();
    bus.set_interp = 1'b0;
  endtask

  task automatic wr_pair(input int i, input int q);
    bus.wr      = 1'b1;
    bus.wr_data = WIDTH'(i);
    step();
    bus.wr_data = WIDTH'(q);
    step();
    bus.wr      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b0 || bus.out_strobe !== 1'b0 || bus.underrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: running=%b strobe=%b underrun=%b, need 0 0 0",
               bus.running, bus.out_strobe, bus.underrun);
    end
    n_cmp++;
    if (bus.count !== (AW+1)'(0) || bus.full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_count: count=%0d full=%b, need 0 0", bus.count, bus.full);
    end
    n_cmp++;
    if (bus.out_i !== WIDTH'(0) || bus.out_q !== WIDTH'(0)) begin
      n_err++;
      $display("FAIL reset_out: out=%0d/%0d, need 0/0", bus.out_i, bus.out_q);
    end
  endtask

  task automatic test_oneshot();
    bit stb;
    int ei, eq, ec;
    ei = 0; eq = 0;
    set_interval(4);
    wr_pair(1, 2);
    wr_pair(3, 4);
    wr_pair(5, 6);
    n_cmp++;
    if (bus.count !== (AW+1)'(3)) begin
      n_err++;
      $display("FAIL oneshot_loaded: count=%0d, need 3", bus.count);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b1 || bus.out_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_enter: running=%b strobe=%b, need 1 0", bus.running, bus.out_strobe);
    end
    for (int c = 1; c <= 18; c++) begin
      bus.wr      = (c == 15 || c == 16);
      bus.wr_data = (c == 15) ? WIDTH'(7) : WIDTH'(8);
      step();
      stb = (c == 2 || c == 6 || c == 10 || c == 14 || c == 18);
      case (c)
        2:       begin ei = 1; eq = 2; end
        6:       begin ei = 3; eq = 4; end
        10:      begin ei = 5; eq = 6; end
        14:      begin ei = 0; eq = 0; end
        18:      begin ei = 7; eq = 8; end
        default: begin end
      endcase
      if (c <= 4) ec = 2;
      else if (c <= 8) ec = 1;
      else if (c == 16) ec = 1;
      else ec = 0;
      n_cmp++;
      if (bus.out_strobe !== stb || bus.out_i !== WIDTH'(ei) || bus.out_q !== WIDTH'(eq)) begin
        n_err++;
        $display("FAIL oneshot_out c%0d: strobe=%b out=%0d/%0d, need %b %0d/%0d",
                 c, bus.out_strobe, bus.out_i, bus.out_q, stb, ei, eq);
      end
      n_cmp++;
      if (bus.count !== (AW+1)'(ec) || bus.underrun !== (c >= 14) || bus.running !== 1'b1) begin
        n_err++;
        $display("FAIL oneshot_state c%0d: count=%0d underrun=%b running=%b, need %0d %b 1",
                 c, bus.count, bus.underrun, bus.running, ec, (c >= 14));
      end
    end
    bus.wr   = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b0 || bus.out_strobe !== 1'b0 || bus.underrun !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_stop: running=%b strobe=%b underrun=%b, need 0 0 1",
               bus.running, bus.out_strobe, bus.underrun);
    end
  endtask

  task automatic test_continuous();
    int ei, eq;
    do_reset();
    set_interval(1);
    wr_pair(10, 11);
    wr_pair(12, 13);
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.wr      = (c == 3 || c == 4);
      bus.wr_data = WIDTH'(99);
      step();
      if (c < 2) begin ei = 0; eq = 0; end
      else if (((c - 2) % 2) == 0) begin ei = 10; eq = 11; end
      else begin ei = 12; eq = 13; end
      n_cmp++;
      if (bus.out_strobe !== (c >= 2) || bus.out_i !== WIDTH'(ei) || bus.out_q !== WIDTH'(eq)) begin
        n_err++;
        $display("FAIL cont_out c%0d: strobe=%b out=%0d/%0d, need %b %0d/%0d",
                 c, bus.out_strobe, bus.out_i, bus.out_q, (c >= 2), ei, eq);
      end
      n_cmp++;
      if (bus.count !== (AW+1)'(2) || bus.underrun !== 1'b0) begin
        n_err++;
        $display("FAIL cont_count c%0d: count=%0d underrun=%b, need 2 0", c, bus.count, bus.underrun);
      end
    end
    bus.wr   = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b0 || bus.out_strobe !== 1'b0 || bus.out_i !== WIDTH'(10) ||
        bus.out_q !== WIDTH'(11) || bus.count !== (AW+1)'(2)) begin
      n_err++;
      $display("FAIL cont_stop: running=%b strobe=%b out=%0d/%0d count=%0d, need 0 0 10/11 2",
               bus.running, bus.out_strobe, bus.out_i, bus.out_q, bus.count);
    end
  endtask

  task automatic test_full();
    int ec;
    do_reset();
    set_interval(1);
    for (int n = 0; n < DEPTH; n++) wr_pair(100 + n, 200 + n);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.count !== (AW+1)'(DEPTH)) begin
      n_err++;
      $display("FAIL full_fill: full=%b count=%0d, need 1 %0d", bus.full, bus.count, DEPTH);
    end
    wr_pair(300, 400);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.count !== (AW+1)'(DEPTH)) begin
      n_err++;
      $display("FAIL full_drop: full=%b count=%0d, need 1 %0d", bus.full, bus.count, DEPTH);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.wr      = (c == 2 || c == 3);
      bus.wr_data = (c == 2) ? WIDTH'(500) : WIDTH'(600);
      step();
      ec = (c == 1) ? 15 : (c == 4) ? 13 : 14;
      n_cmp++;
      if (bus.count !== (AW+1)'(ec)) begin
        n_err++;
        $display("FAIL full_pop c%0d: count=%0d, need %0d", c, bus.count, ec);
      end
      if (c >= 2) begin
        n_cmp++;
        if (bus.out_strobe !== 1'b1 || bus.out_i !== WIDTH'(98 + c) || bus.out_q !== WIDTH'(198 + c)) begin
          n_err++;
          $display("FAIL full_out c%0d: strobe=%b out=%0d/%0d, need 1 %0d/%0d",
                   c, bus.out_strobe, bus.out_i, bus.out_q, 98 + c, 198 + c);
        end
      end
    end
    bus.wr   = 1'b0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_cmp++;
    if (bus.count !== (AW+1)'(14) || bus.out_strobe !== 1'b0 || bus.out_i !== WIDTH'(102)) begin
      n_err++;
      $display("FAIL full_stop: count=%0d strobe=%b out_i=%0d, need 14 0 102",
               bus.count, bus.out_strobe, bus.out_i);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.out_strobe !== 1'b1 || bus.out_i !== WIDTH'(103) || bus.out_q !== WIDTH'(203)) begin
      n_err++;
      $display("FAIL full_resume: strobe=%b out=%0d/%0d, need 1 103/203",
               bus.out_strobe, bus.out_i, bus.out_q);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_interval(3);
    wr_pair(21, 22);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus.wr = (c >= 6 && c <= 9);
      case (c)
        6:       bus.wr_data = WIDTH'(25);
        7:       bus.wr_data = WIDTH'(26);
        8:       bus.wr_data = WIDTH'(27);
        default: bus.wr_data = WIDTH'(28);
      endcase
      step();
      if (c == 2) begin
        n_cmp++;
        if (bus.out_strobe !== 1'b1 || bus.out_i !== WIDTH'(21) || bus.out_q !== WIDTH'(22)) begin
          n_err++;
          $display("FAIL mid_first: strobe=%b out=%0d/%0d, need 1 21/22",
                   bus.out_strobe, bus.out_i, bus.out_q);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (bus.out_strobe !== 1'b1 || bus.underrun !== 1'b1 || bus.out_i !== WIDTH'(0)) begin
          n_err++;
          $display("FAIL mid_underrun: strobe=%b underrun=%b out_i=%0d, need 1 1 0",
                   bus.out_strobe, bus.underrun, bus.out_i);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if (bus.out_strobe !== 1'b1 || bus.out_i !== WIDTH'(25) || bus.out_q !== WIDTH'(26) ||
            bus.count !== (AW+1)'(1) || bus.running !== 1'b1) begin
          n_err++;
          $display("FAIL mid_resume: strobe=%b out=%0d/%0d count=%0d running=%b, need 1 25/26 1 1",
                   bus.out_strobe, bus.out_i, bus.out_q, bus.count, bus.running);
        end
      end
    end
    bus.wr = 1'b0;
    do_reset();
    n_cmp++;
    if (bus.running !== 1'b0 || bus.count !== (AW+1)'(0) || bus.out_i !== WIDTH'(0) ||
        bus.out_q !== WIDTH'(0) || bus.underrun !== 1'b0 || bus.out_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: running=%b count=%0d out=%0d/%0d underrun=%b strobe=%b, need 0 0 0/0 0 0",
               bus.running, bus.count, bus.out_i, bus.out_q, bus.underrun, bus.out_strobe);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    n_cmp++;
    if (bus.running !== 1'b0) begin
      n_err++;
      $display("FAIL empty_start: running=%b, need 0", bus.running);
    end
  endtask

  task automatic test_start_stop_and_zero_interp();
    wr_pair(31, 32);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step();
    n_cmp++;
    if (bus.running !== 1'b0 || bus.out_strobe !== 1'b0 || bus.count !== (AW+1)'(1)) begin
      n_err++;
      $display("FAIL start_stop: running=%b strobe=%b count=%0d, need 0 0 1",
               bus.running, bus.out_strobe, bus.count);
    end
    set_interval(5);
    set_interval(0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++;
      if (bus.out_strobe !== (c >= 2)) begin
        n_err++;
        $display("FAIL interp_zero c%0d: strobe=%b, need %b", c, bus.out_strobe, (c >= 2));
      end
      if (c == 2) begin
        n_cmp++;
        if (bus.out_i !== WIDTH'(31) || bus.out_q !== WIDTH'(32)) begin
          n_err++;
          $display("FAIL interp_zero_data: out=%0d/%0d, need 31/32", bus.out_i, bus.out_q);
        end
      end
    end
    n_cmp++;
    if (bus.underrun !== 1'b1 || bus.out_i !== WIDTH'(0)) begin
      n_err++;
      $display("FAIL interp_zero_underrun: underrun=%b out_i=%0d, need 1 0", bus.underrun, bus.out_i);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_full();
    test_reset_mid_run();
    test_start_stop_and_zero_interp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
